// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: state encoding,
// TX output mux select codes and the default frame data width.
package uart_tx_pkg;

  // Binary-encoded FSM state, 3 bits wide.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Select codes for the downstream registered TX mux.
  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  // Default number of data bits per frame (legal range 5..9).
  localparam int DATA_WIDTH_DEF = 8;

  // Moore decode of the mux select from the FSM state. Unused encodings
  // fall back to the idle/stop level so the line stays high.
  function automatic logic [1:0] mux_sel_of(input state_t st);
    logic [1:0] sel;
    sel = MUX_STOP;
    case (st)
      ST_START:  sel = MUX_START;
      ST_DATA:   sel = MUX_DATA;
      ST_PARITY: sel = MUX_PAR;
      default:   sel = MUX_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data-bit serializer: holds the captured word in a right-shifting register,
// counts transmitted data bits and flags the last one. The current bit is
// always shift_q[0].
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic                  ser_data_o,
  output logic                  done_o
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done;

  assign done = (cnt_q == CW'(DATA_WIDTH - 1));

  // Next-state for shift register and bit counter. The final data bit is not
  // shifted out, so ser_data holds that bit after DATA instead of toggling;
  // the counter wraps to zero on that same cycle, clearing it on exit.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_in_i;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      if (done) begin
        cnt_d = '0;
      end else begin
        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_data_o = shift_q[0];
  assign done_o     = done;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit controller. Sequences start, DATA_WIDTH data bits LSB first,
// optional parity and stop, one bit per baud clock, by steering the
// downstream registered TX mux. The line therefore lags mux_sel by one cycle.
//
// Request handshake: DATA_VALID is a one-sided valid with no ready. A word is
// taken on any edge where DATA_VALID=1 and the FSM is in IDLE or STOP; in every
// other state the request is dropped, not queued. busy=1 marks the cycles in
// which a request would be ignored, except STOP, which also accepts.
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy,
  output logic [2:0]            state_dbg_o
);

  state_t state_q, state_d;
  logic   par_en_q, par_en_d;
  logic   par_bit_q, par_bit_d;
  logic   accept;
  logic   shift_en;
  logic   ser_done;

  // A new word is taken only when the line is idle or finishing its stop bit.
  assign accept   = DATA_VALID && ((state_q == ST_IDLE) || (state_q == ST_STOP));
  assign shift_en = (state_q == ST_DATA);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (accept),
    .shift_en_i (shift_en),
    .data_in_i  (P_DATA),
    .ser_data_o (ser_data),
    .done_o     (ser_done)
  );

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_START;
      ST_START:  state_d = ST_DATA;
      ST_DATA:   if (ser_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = accept ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Frame options and parity are captured once per accepted word so that
  // later input changes cannot disturb the frame in flight.
  always_comb begin
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (accept) begin
      par_en_d  = PAR_EN;
      par_bit_d = (^P_DATA) ^ PAR_TYP;
    end
  end

  // Registers with synchronous active-high reset; reset aborts any frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  // Moore outputs, decoded from the state register only.
  always_comb begin
    mux_sel = mux_sel_of(state_q);
    busy    = (state_q != ST_IDLE);
  end

  assign par_bit     = par_bit_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm with a model of the downstream registered
// TX mux, so the serial line can be checked as well as the select codes.
module tb_uart_tx_fsm;
  import uart_tx_pkg::*;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] P_DATA = '0;
  logic         DATA_VALID = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [1:0]   mux_sel;
  logic         ser_data;
  logic         par_bit;
  logic         busy;
  logic [2:0]   state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  logic exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  uart_tx_fsm #(.DATA_WIDTH(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .P_DATA      (P_DATA),
    .DATA_VALID  (DATA_VALID),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .mux_sel     (mux_sel),
    .ser_data    (ser_data),
    .par_bit     (par_bit),
    .busy        (busy),
    .state_dbg_o (state_dbg)
  );

  // Downstream registered mux (no reset of its own): TX_OUT follows mux_sel
  // one cycle later.
  logic tx_out = 1'b1;
  always @(posedge CLK) begin
    case (mux_sel)
      2'b00:   tx_out <= 1'b0;
      2'b01:   tx_out <= 1'b1;
      2'b10:   tx_out <= ser_data;
      default: tx_out <= par_bit;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word with DATA_VALID for one edge; leaves the DUT in START.
  task automatic accept(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    // Scramble inputs mid-frame; they must not affect the frame in flight.
    P_DATA  = ~d;
    PAR_EN  = ~pe;
    PAR_TYP = ~pt;
  endtask

  // Check a frame starting from the START cycle. Optionally pulse DATA_VALID
  // with 0x00 in DATA cycle 3, and optionally chain a new word in STOP.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic glitch, input logic chain,
                           input logic [7:0] nd, input logic npe, input logic npt);
    logic exp_par;
    exp_par = (^d) ^ pt;
    chk("start_sel", 8'(mux_sel), 8'(MUX_START));
    chk("start_busy", 8'(busy), 8'd1);
    chk("start_state", 8'(state_dbg), 8'(ST_START));
    for (int i = 0; i < W; i++) begin
      tick();
      chk($sformatf("data%0d_sel", i), 8'(mux_sel), 8'(MUX_DATA));
      chk($sformatf("data%0d_bit", i), 8'(ser_data), 8'(d[i]));
      chk($sformatf("data%0d_busy", i), 8'(busy), 8'd1);
      if (glitch && i == 3) begin
        P_DATA     = 8'h00;
        DATA_VALID = 1'b1;
      end else begin
        DATA_VALID = 1'b0;
      end
    end
    if (pe) begin
      tick();
      chk("par_sel", 8'(mux_sel), 8'(MUX_PAR));
      chk("par_bit", 8'(par_bit), 8'(exp_par));
      chk("par_busy", 8'(busy), 8'd1);
    end
    tick();
    chk("stop_sel", 8'(mux_sel), 8'(MUX_STOP));
    chk("stop_busy", 8'(busy), 8'd1);
    chk("stop_state", 8'(state_dbg), 8'(ST_STOP));
    if (chain) begin
      P_DATA     = nd;
      PAR_EN     = npe;
      PAR_TYP    = npt;
      DATA_VALID = 1'b1;
    end
    tick();
    DATA_VALID = 1'b0;
    if (!chain) begin
      chk("idle_sel", 8'(mux_sel), 8'(MUX_STOP));
      chk("idle_busy", 8'(busy), 8'd0);
      chk("idle_state", 8'(state_dbg), 8'(ST_IDLE));
    end else begin
      P_DATA  = ~nd;
      PAR_EN  = ~npe;
      PAR_TYP = ~npt;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] d;

    // Reset, then hold idle for 5 cycles.
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_sel", 8'(mux_sel), 8'h01);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_ser", 8'(ser_data), 8'd0);
    chk("rst_par", 8'(par_bit), 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_hold_sel", 8'(mux_sel), 8'h01);
      chk("idle_hold_busy", 8'(busy), 8'd0);
      chk("idle_hold_par", 8'(par_bit), 8'd0);
    end

    // 0xA5, no parity: 10-cycle frame.
    accept(8'hA5, 1'b0, 1'b0);
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 0xA5 with even then odd parity: 11-cycle frames, par_bit 0 then 1.
    accept(8'hA5, 1'b1, 1'b0);
    chk("a5_even_par", 8'(par_bit), 8'd0);
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    accept(8'hA5, 1'b1, 1'b1);
    chk("a5_odd_par", 8'(par_bit), 8'd1);
    run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Back-to-back 0x3C then 0xFF (odd parity), with an ignored mid-DATA pulse.
    accept(8'h3C, 1'b0, 1'b0);
    run_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    run_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset in the 4th DATA cycle of 0xA5 aborts the frame.
    accept(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_state", 8'(state_dbg), 8'(ST_DATA));
    chk("pre_rst_bit3", 8'(ser_data), 8'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_sel", 8'(mux_sel), 8'h01);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_tx_lag", 8'(tx_out), 8'd0);
    tick();
    chk("abort_tx_idle", 8'(tx_out), 8'd1);
    accept(8'h81, 1'b1, 1'b1);
    chk("x81_odd_par", 8'(par_bit), 8'd1);
    run_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Serial line through the mux: 0xA5 with odd parity, one cycle behind.
    tick();
    d = 8'hA5;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    accept(d, 1'b1, 1'b1);
    chk("tx_before_start", 8'(tx_out), 8'd1);
    for (int i = 0; i < W + 3; i++) begin
      logic e;
      tick();
      e = exp_q.pop_front();
      chk($sformatf("tx_bit%0d", i), 8'(tx_out), 8'(e));
    end
    chk("tx_end_busy", 8'(busy), 8'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- UART transmit controller that sits directly upstream of the registered TX output mux.
- Accepts a parallel word with a valid strobe, then sequences one frame: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit.
- Drives mux_sel and the serial data and parity bits into the mux, one bit per CLK cycle. CLK is the divided baud clock.
- The mux register adds one cycle, so the line (TX_OUT) lags mux_sel by exactly 1 cycle.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
- CLK  input  1  baud-rate clock; the single clock of the block.
- RST  input  1  reset, synchronous, active-high.
- P_DATA  input  DATA_WIDTH  parallel word; sampled only on acceptance.
- DATA_VALID  input  1  word request; accepted only in IDLE or STOP.
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on acceptance.
- mux_sel  output  2  selects the mux input: 00 start, 01 stop/idle, 10 serial data, 11 parity.
- ser_data  output  1  current data bit, driven into mux IN_2.
- par_bit  output  1  frame parity bit, driven into mux IN_3.
- busy  output  1  high while a frame is in progress.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP.
- mux_sel is Moore-decoded from the state:
  - IDLE → 01
  - START → 00
  - DATA → 10
  - PARITY → 11
  - STOP → 01
- busy = (state != IDLE).
- Reset (RST high at a CLK edge):
  - state → IDLE, mux_sel → 01, busy → 0, ser_data → 0, par_bit → 0.
  - Bit counter and shift register are cleared.
- Reset mid-frame aborts the frame at the next edge and discards the captured word. The line returns to 1 one cycle later, via the mux register.
- Acceptance: in IDLE, or in the final STOP cycle, with DATA_VALID = 1.
  - P_DATA is loaded into the shift register; PAR_EN and PAR_TYP are latched.
  - par_bit is registered as XOR-reduce(P_DATA) XOR PAR_TYP.
  - Next state is START.
- DATA_VALID in START, DATA or PARITY is ignored. There is no queuing; the word is lost.
- START lasts 1 cycle → DATA.
- DATA lasts DATA_WIDTH cycles. ser_data = shift_reg[0]. The shift register shifts right and the bit counter increments at the end of each DATA cycle.
  - When counter = DATA_WIDTH-1: go to PARITY if the latched PAR_EN = 1, else to STOP.
  - The counter clears on leaving DATA.
- PARITY lasts 1 cycle → STOP.
- STOP lasts 1 cycle → START on acceptance, else IDLE.
- Frame length from the START cycle to the end of STOP is DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- Back-to-back frames: DATA_VALID in the STOP cycle gives START on the next cycle. busy stays 1 with no idle gap.
- Changes to P_DATA, PAR_EN or PAR_TYP mid-frame have no effect on the frame in flight.
- ser_data is don't-care outside DATA but is held at its last value (no toggling) to limit power.
- No combinational path from any input to mux_sel.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), binary encoded, 3 bits;
  - mux_sel constants MUX_START = 2'b00, MUX_STOP = 2'b01, MUX_DATA = 2'b10, MUX_PAR = 2'b11;
  - default DATA_WIDTH.
- One sub-module, uart_tx_serializer: shift register, bit counter and a done flag (counter = DATA_WIDTH-1). Its ports are load, shift_en, data_in, ser_data and done.
- Parity and the FSM live in uart_tx_fsm.

Test Plan:
- Reset, hold DATA_VALID = 0 for 5 cycles → mux_sel = 01, busy = 0, par_bit = 0 every cycle.
- P_DATA = 0xA5, PAR_EN = 0, one-cycle DATA_VALID in IDLE →
  - mux_sel = 00, then 10 ×8, then 01, over 10 cycles;
  - ser_data = 1,0,1,0,0,1,0,1;
  - busy high for exactly 10 cycles, then IDLE.
- P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0 → 11-cycle frame, mux_sel = 11 in cycle 10, par_bit = 0. Repeat with PAR_TYP = 1 → par_bit = 1.
- Back-to-back: 0x3C, then 0xFF with DATA_VALID asserted in the STOP cycle → the second START directly follows STOP, busy never drops. A DATA_VALID pulse mid-DATA (P_DATA = 0x00) is ignored and the transmitted bits are unchanged.
- RST asserted in the 4th DATA cycle of 0xA5 → next edge: mux_sel = 01, busy = 0; the following frame 0x81 transmits correctly from bit 0.
- With the downstream mux attached: TX_OUT equals the expected frame bit stream delayed by exactly 1 cycle for 0xA5 with odd parity.
